// File: rtl/data_mem_responder_if.sv
//==============================================================================
// Module : data_mem_responder_if
// Brief  : CPU-side data-memory request/response bundle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//==============================================================================
// Module : data_mem_responder
// Brief  : Word-addressed data memory with programmable wait states.
//          Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned accesses.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  data_mem_responder_if.slave   bus
);

  localparam int         c_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [c_DEPTH];

  logic                w_accept;
  logic                w_wr;
  logic                w_rd;
  logic                w_mis;
  logic                w_unused_addr;

  // Bits above the word index and the byte offset never select storage.
  assign w_unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_mis;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        r_mis <= 1'b0;
    else if (w_accept) r_mis <= |bus.addr_i[1:0];
  end
  assign w_mis = r_mis;
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= c_WAIT;
        r_we    <= bus.we_i;
        r_idx   <= bus.addr_i[ADDR_W+1:2];
        r_wdata <= bus.wdata_i;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd) r_rdata <= r_mem[r_idx];
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          w_accept = 1'b1;
          w_next   = (c_WAIT != 4'd0) ? S_BUSY : S_RESP;
        end
      end
      S_BUSY: begin
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
        w_wr   = r_we & ~w_mis;
        w_rd   = ~r_we & ~w_mis;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Storage is intentionally left out of reset so contents survive an abort.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_idx] <= r_wdata;
  end

  assign bus.ack_o   = (r_state == S_RESP);
  assign bus.err_o   = (r_state == S_RESP) & w_mis;
  assign bus.rdata_o = w_rd ? r_mem[r_idx] : r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//==============================================================================
// Module : tb_data_mem_responder
// Brief  : Randomized bench for data_mem_responder against an array model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_data_mem_responder;
  localparam int ADDR_W   = 8;
  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );
  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus0)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One transaction on the WAIT_CYC=2 instance; drop releases req after acceptance.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit drop);
    int          n      = 0;
    bit          got    = 1'b0;
    int          idx    = int'(addr >> 2) % DEPTH;
    bit          mis    = misal(addr);
    logic [31:0] exp_rd = (!we && !mis) ? model[idx] : last_rd;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wd;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (drop) bus.req_i = 1'b0;
      if (bus.ack_o) got = 1'b1;
    end
    bus.req_i = 1'b0;
    check("latency", 32'(n), 32'(WAIT_CYC + 1));
    check("rdata", bus.rdata_o, exp_rd);
    check("err", 32'(bus.err_o), 32'(mis));
    if (!mis) begin
      if (we) model[idx] = wd;
      else    last_rd    = model[idx];
    end
    @(posedge clk); #1;
    check("ack_pulse", 32'(bus.ack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v0, v1;
    bit          we_s [4];
    logic [31:0] ad_s [4];
    logic [31:0] wd_s [4];
    logic [31:0] rd_s [4];

    bus.req_i  = 1'b0; bus.we_i  = 1'b0; bus.addr_i  = '0; bus.wdata_i  = '0;
    bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    check("rst_ack0", 32'(bus0.ack_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 1'b0);
    txn(1'b1, 32'h14, 32'h01020304, 1'b0);
    txn(1'b1, 32'h400, 32'h12345678, 1'b0);
    txn(1'b0, 32'h000, 32'h0, 1'b0);

    // Abort a store with reset one cycle after it is accepted.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b0;
    #1;
    bus.req_i = 1'b0;
    check("abort_rdata", bus.rdata_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_ack", 32'(bus.ack_o), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    last_rd = 32'd0;
    txn(1'b0, 32'h20, 32'h0, 1'b0);

    txn(1'b1, 32'h22, 32'hAAAAAAAA, 1'b0);
    txn(1'b0, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) a[31:ADDR_W+2] = '0;
      txn(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    // Zero-wait instance with req held high across four transactions.
    v0 = $urandom; v1 = $urandom;
    we_s = '{1'b1, 1'b1, 1'b0, 1'b0};
    ad_s = '{32'h40, 32'h44, 32'h40, 32'h44};
    wd_s = '{v0, v1, 32'h0, 32'h0};
    rd_s = '{32'h0, 32'h0, v0, v1};
    @(negedge clk);
    bus0.req_i = 1'b1; bus0.we_i = we_s[0]; bus0.addr_i = ad_s[0]; bus0.wdata_i = wd_s[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("w0_ack", 32'(bus0.ack_o), 32'd1);
      check("w0_rdata", bus0.rdata_o, rd_s[k]);
      if (k < 3) begin
        bus0.we_i = we_s[k+1]; bus0.addr_i = ad_s[k+1]; bus0.wdata_i = wd_s[k+1];
      end else begin
        bus0.req_i = 1'b0;
      end
      @(posedge clk); #1;
      check("w0_gap", 32'(bus0.ack_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving word-address bits (depth 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter WAIT_CYC, default 2, giving wait cycles inserted before each acknowledge (range 0..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_i.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 req_i  input  1  CPU-side access request; held high until ack_o.
REQ-007 we_i  input  1  1 = store, 0 = load; sampled with req_i.
REQ-008 addr_i  input  32  byte address; sampled with req_i.
REQ-009 wdata_i  input  32  store data; sampled with req_i.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  32  load data, valid in the ack_o cycle.
REQ-012 err_o  output  1  misaligned-access flag, valid in the ack_o cycle.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE with req_i=1, the block SHALL capture we_i, addr_i, wdata_i and load the wait counter with WAIT_CYC.
REQ-015 From IDLE the block SHALL go to BUSY if WAIT_CYC>0, else directly to RESP.
REQ-016 In BUSY the counter SHALL decrement each cycle; at count 1 the next state SHALL be RESP.
REQ-017 In RESP ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 Latency: ack_o SHALL assert WAIT_CYC+1 cycles after the edge sampling req_i.
REQ-019 Word index SHALL be captured addr[ADDR_W+1:2]; higher address bits SHALL be ignored (address wraps modulo depth).
REQ-020 Stores SHALL update memory at the clock edge ending the RESP cycle, using captured data.
REQ-021 Loads SHALL drive rdata_o with the addressed word in the RESP cycle; rdata_o SHALL hold its last load value otherwise, including across stores.
REQ-022 req_i SHALL be ignored in BUSY and RESP; a request dropped mid-transaction SHALL still complete with ack_o.
REQ-023 Back-to-back: req_i held high after ack_o SHALL be accepted in the following IDLE cycle (one idle cycle minimum between transactions).
REQ-024 A load from a word stored in the preceding transaction SHALL return the new data.

Reset
REQ-025 On rst_i=0 the FSM SHALL enter IDLE immediately; ack_o=0, err_o=0, rdata_o=0, counter=0.
REQ-026 Reset mid-transaction SHALL abort it with no memory write and no ack_o.
REQ-027 Memory array contents SHALL NOT be reset.

Configuration
REQ-028 With macro DMEM_MISALIGN_CHECK_EN defined, a request with addr[1:0]!=0 SHALL complete with normal latency, err_o=1 with ack_o, no memory write, and rdata_o unchanged.
REQ-029 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored and err_o SHALL be tied 0.

Verification
REQ-030 Reset then store 0xDEADBEEF to 0x10, WAIT_CYC=2 -> ack_o exactly 3 cycles after request, single-cycle pulse.
REQ-031 Load from 0x10 after REQ-030 -> rdata_o=0xDEADBEEF with ack_o; subsequent store to 0x14 leaves rdata_o=0xDEADBEEF.
REQ-032 ADDR_W=8, store 0x12345678 to 0x400, load 0x000 -> rdata_o=0x12345678 (wrap-around).
REQ-033 Store to 0x20, rst_i low one cycle after request -> no ack_o; load 0x20 after reset returns prior contents.
REQ-034 DMEM_MISALIGN_CHECK_EN defined, store 0xAAAAAAAA to 0x22 -> ack_o with err_o=1; load 0x20 returns unchanged word with err_o=0.
REQ-035 WAIT_CYC=0, req_i held high for two loads -> ack_o 1 cycle after each acceptance, one idle cycle between acks.
